// File: rtl/vector_alu_seq_if.sv
`default_nettype none
// ============================================================================
// vector_alu_seq_if : request/result bundle between a requester and vector_alu_seq
// Revision: 1.0
// ============================================================================
interface vector_alu_seq_if #(
  parameter int WIDTH        = 24,
  parameter int VECTOR_WIDTH = 8
);
  logic                                in_valid;
  logic                                in_ready;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  A;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  B;
  logic [2:0]                          sel;
  logic [VECTOR_WIDTH-1:0]             mask;
  logic                                out_valid;
  logic                                out_ready;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  Out;
  logic                                N;
  logic                                Z;
  logic                                V;
  logic                                C;

  modport master (
    output in_valid, A, B, sel, mask, out_ready,
    input  in_ready, out_valid, Out, N, Z, V, C
  );

  modport slave (
    input  in_valid, A, B, sel, mask, out_ready,
    output in_ready, out_valid, Out, N, Z, V, C
  );
endinterface
`default_nettype wire

// File: rtl/vector_alu_seq.sv
`default_nettype none
// ============================================================================
// vector_alu_seq : multi-cycle masked vector ALU, LANES elements per cycle
// Revision: 1.0
// ============================================================================
module vector_alu_seq #(
  parameter int WIDTH        = 24,
  parameter int VECTOR_WIDTH = 8,
  parameter int LANES        = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  vector_alu_seq_if.slave  bus
);
  localparam int              c_EL_W     = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam logic [c_EL_W-1:0] c_LAST_IDX = c_EL_W'(VECTOR_WIDTH - LANES);
  localparam logic [c_EL_W-1:0] c_LANE_STEP = c_EL_W'(LANES);
  localparam logic [WIDTH-1:0]  c_W_MOD    = WIDTH'(WIDTH);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SUB = 3'b001;
  localparam logic [2:0] c_OP_MUL = 3'b010;
  localparam logic [2:0] c_OP_AND = 3'b011;
  localparam logic [2:0] c_OP_OR  = 3'b100;
  localparam logic [2:0] c_OP_XOR = 3'b101;
  localparam logic [2:0] c_OP_SLL = 3'b110;

  generate
    if ((LANES < 1) || (VECTOR_WIDTH % LANES != 0)) begin : g_bad_lanes
      $error("vector_alu_seq: LANES must be >0 and divide VECTOR_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                              state_q, state_d;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  a_q, a_d;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  b_q, b_d;
  logic [VECTOR_WIDTH-1:0][WIDTH-1:0]  out_q, out_d;
  logic [2:0]                          sel_q, sel_d;
  logic [VECTOR_WIDTH-1:0]             mask_q, mask_d;
  logic [c_EL_W-1:0]                   idx_q, idx_d;
  logic                                n_q, n_d;
  logic                                z_q, z_d;
  logic                                v_q, v_d;
  logic                                c_q, c_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    n_d     = n_q;
    z_d     = z_q;
    v_d     = v_q;
    c_d     = c_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.A;
          b_d     = bus.B;
          sel_d   = bus.sel;
          mask_d  = bus.mask;
          idx_d   = '0;
          n_d     = 1'b0;
          z_d     = 1'b1;
          v_d     = 1'b0;
          c_d     = 1'b0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        for (int l = 0; l < LANES; l++) begin : lane_calc
          logic [c_EL_W-1:0]   e;
          logic [WIDTH-1:0]    ea;
          logic [WIDTH-1:0]    eb;
          logic [WIDTH-1:0]    res;
          logic [WIDTH:0]      sum;
          logic [WIDTH:0]      dif;
          logic [2*WIDTH-1:0]  prod;
          logic                act;
          logic                cy;
          logic                ov;

          e    = idx_q + c_EL_W'(l);
          ea   = a_q[e];
          eb   = b_q[e];
          act  = mask_q[e];
          sum  = {1'b0, ea} + {1'b0, eb};
          dif  = {1'b0, ea} + {1'b0, ~eb} + {{WIDTH{1'b0}}, 1'b1};
          prod = {{WIDTH{1'b0}}, ea} * {{WIDTH{1'b0}}, eb};
          res  = ea;
          cy   = 1'b0;
          ov   = 1'b0;

          case (sel_q)
            c_OP_ADD: begin
              res = sum[WIDTH-1:0];
              cy  = sum[WIDTH];
              ov  = (ea[WIDTH-1] == eb[WIDTH-1]) && (res[WIDTH-1] != ea[WIDTH-1]);
            end
            c_OP_SUB: begin
              res = dif[WIDTH-1:0];
              cy  = dif[WIDTH];
              ov  = (ea[WIDTH-1] != eb[WIDTH-1]) && (res[WIDTH-1] != ea[WIDTH-1]);
            end
            c_OP_MUL: begin
              res = prod[WIDTH-1:0];
              cy  = |prod[2*WIDTH-1:WIDTH];
              ov  = cy;
            end
            c_OP_AND: res = ea & eb;
            c_OP_OR:  res = ea | eb;
            c_OP_XOR: res = ea ^ eb;
            c_OP_SLL: res = ea << (eb % c_W_MOD);
            default:  res = ea;
          endcase

          // Inactive lanes pass A through and leave the flag accumulators alone
          if (!act) begin
            res = ea;
          end
          out_d[e] = res;
          n_d      = n_d | (act & res[WIDTH-1]);
          z_d      = z_d & ~(act & (|res));
          c_d      = c_d | (act & cy);
          v_d      = v_d | (act & ov);
        end

        if (idx_q == c_LAST_IDX) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + c_LANE_STEP;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      sel_q   <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      z_q     <= z_d;
      v_q     <= v_d;
      c_q     <= c_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.Out       = out_q;
  assign bus.N         = n_q;
  assign bus.Z         = z_q;
  assign bus.V         = v_q;
  assign bus.C         = c_q;
endmodule
`default_nettype wire

// File: tb/tb_vector_alu_seq.sv
`default_nettype none
// ============================================================================
// tb_vector_alu_seq : directed table, corner sequences and random ops vs. model
// Revision: 1.0
// ============================================================================
module tb_vector_alu_seq;
  localparam int W  = 24;
  localparam int VW = 8;
  localparam int L  = 2;
  localparam longint M = longint'(1) << W;
  localparam longint H = M / 2;

  typedef logic [VW-1:0][W-1:0] vec_t;
  typedef logic [VW*W-1:0]      wide_t;
  typedef struct {
    vec_t          a;
    vec_t          b;
    logic [2:0]    sel;
    logic [VW-1:0] mask;
    vec_t          out;
    logic [3:0]    f;
  } tv_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  tv_t  tbl[7];

  vector_alu_seq_if #(.WIDTH(W), .VECTOR_WIDTH(VW)) bus ();

  vector_alu_seq #(.WIDTH(W), .VECTOR_WIDTH(VW), .LANES(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input wide_t act, input wide_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < VW; i++) v[i] = W'($urandom);
    return v;
  endfunction

  function automatic longint sgn(input longint x);
    return (x >= H) ? x - M : x;
  endfunction

  function automatic bit ovf(input longint s);
    return (s < -H) || (s >= H);
  endfunction

  // Reference: plain integer arithmetic on each element
  function automatic void model(input vec_t a, input vec_t b, input logic [2:0] s,
                                input logic [VW-1:0] m, output vec_t o, output logic [3:0] f);
    logic n = 1'b0, z = 1'b1, v = 1'b0, c = 1'b0;
    for (int i = 0; i < VW; i++) begin
      longint x, y, t, r;
      bit cc, vv;
      x = longint'(a[i]); y = longint'(b[i]); cc = 0; vv = 0; t = 0; r = 0;
      case (s)
        3'd0: begin t = x + y;             cc = (t >= M); vv = ovf(sgn(x) + sgn(y)); r = t % M; end
        3'd1: begin t = x + (M - 1 - y) + 1; cc = (t >= M); vv = ovf(sgn(x) - sgn(y)); r = t % M; end
        3'd2: begin t = x * y;             cc = (t >= M); vv = cc;                   r = t % M; end
        3'd3: r = x & y;
        3'd4: r = x | y;
        3'd5: r = x ^ y;
        3'd6: r = (x << (y % W)) % M;
        default: r = x;
      endcase
      if (m[i]) begin
        n |= (r >= H); z &= (r == 0); c |= cc; v |= vv;
      end else begin
        r = x;
      end
      o[i] = W'(r);
    end
    f = {n, z, v, c};
  endfunction

  task automatic run_op(input string tag, input vec_t a, input vec_t b, input logic [2:0] s,
                        input logic [VW-1:0] m, input vec_t eo, input logic [3:0] ef, input int hold);
    int lat;
    bit bad_hs;
    @(negedge clk);
    chk({tag, " in_ready"}, wide_t'(bus.in_ready), wide_t'(1));
    bus.A = a; bus.B = b; bus.sel = s; bus.mask = m; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      bus.A = rand_vec(); bus.B = rand_vec(); bus.sel = 3'($urandom); bus.mask = VW'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, wide_t'(lat), wide_t'(VW / L));
    bad_hs = 0;
    repeat (hold) begin
      bus.A = rand_vec(); bus.B = rand_vec(); bus.in_valid = 1'($urandom);
      bus.sel = 3'($urandom); bus.mask = VW'($urandom);
      @(posedge clk); #1;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad_hs = 1;
    end
    chk({tag, " hold handshake"}, wide_t'(bad_hs), wide_t'(0));
    chk({tag, " Out"}, wide_t'(bus.Out), wide_t'(eo));
    chk({tag, " NZVC"}, wide_t'({bus.N, bus.Z, bus.V, bus.C}), wide_t'(ef));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk({tag, " after handoff rdy/vld"}, wide_t'({bus.in_ready, bus.out_valid}), wide_t'(2'b10));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t eo;
    logic [3:0] ef;
    bit seen;

    for (int i = 0; i < VW; i++) begin
      tbl[0].a[i] = W'(i + 1); tbl[0].b[i] = W'(i + 1); tbl[0].out[i] = W'(2 * (i + 1));
      tbl[1].a[i] = W'(i + 1); tbl[1].b[i] = W'(i + 1); tbl[1].out[i] = '0;
      tbl[2].a[i] = W'(i + 1); tbl[2].b[i] = W'(i + 3); tbl[2].out[i] = W'(i + 1);
      tbl[3].a[i] = W'(i + 1); tbl[3].b[i] = W'(i + 3); tbl[3].out[i] = W'(i + 1);
      tbl[4].a[i] = W'(1);     tbl[4].b[i] = W'(i);     tbl[4].out[i] = W'(1 << i);
      tbl[5].a[i] = 24'h800000; tbl[5].b[i] = 24'h800000; tbl[5].out[i] = 24'h800000;
      tbl[6].a[i] = 24'hFFFFFF; tbl[6].b[i] = '0;       tbl[6].out[i] = '0;
    end
    tbl[0].sel = 3'd0; tbl[0].mask = 8'hFF; tbl[0].f = 4'b0000;
    tbl[1].sel = 3'd1; tbl[1].mask = 8'hFF; tbl[1].f = 4'b0101;
    tbl[2].a[0] = 24'h001000; tbl[2].b[0] = 24'h001000; tbl[2].out[0] = 24'h000000;
    tbl[2].sel = 3'd2; tbl[2].mask = 8'h01; tbl[2].f = 4'b0111;
    tbl[3].a[0] = 24'h7FFFFF; tbl[3].b[0] = 24'h000001; tbl[3].out[0] = 24'h800000;
    tbl[3].sel = 3'd0; tbl[3].mask = 8'h01; tbl[3].f = 4'b1010;
    tbl[4].b[7] = W'(25); tbl[4].out[7] = W'(2);
    tbl[4].sel = 3'd6; tbl[4].mask = 8'hFF; tbl[4].f = 4'b0000;
    tbl[5].sel = 3'd0; tbl[5].mask = 8'h00; tbl[5].f = 4'b0100;
    tbl[6].sel = 3'd3; tbl[6].mask = 8'hFF; tbl[6].f = 4'b0100;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.sel = '0; bus.mask = '0;
    bus.A = '0; bus.B = '0;

    // Asynchronous reset: outputs must clear before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("reset rdy/vld", wide_t'({bus.in_ready, bus.out_valid}), wide_t'(2'b10));
    chk("reset Out", wide_t'(bus.Out), wide_t'(0));
    chk("reset NZVC", wide_t'({bus.N, bus.Z, bus.V, bus.C}), wide_t'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int t = 0; t < 7; t++)
      run_op($sformatf("table%0d", t), tbl[t].a, tbl[t].b, tbl[t].sel, tbl[t].mask,
             tbl[t].out, tbl[t].f, 0);

    // Result held for 5 cycles while inputs and in_valid toggle
    run_op("hold5", tbl[3].a, tbl[3].b, tbl[3].sel, tbl[3].mask, tbl[3].out, tbl[3].f, 5);

    // Reset during the second RUN cycle aborts the operation
    @(negedge clk);
    bus.A = tbl[0].a; bus.B = tbl[0].b; bus.sel = 3'd0; bus.mask = 8'hFF; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrun reset rdy/vld", wide_t'({bus.in_ready, bus.out_valid}), wide_t'(2'b10));
    chk("midrun reset Out", wide_t'(bus.Out), wide_t'(0));
    chk("midrun reset NZVC", wide_t'({bus.N, bus.Z, bus.V, bus.C}), wide_t'(0));
    seen = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("midrun no out_valid", wide_t'(seen), wide_t'(0));
    run_op("post-reset add", tbl[0].a, tbl[0].b, 3'd0, 8'hFF, tbl[0].out, 4'b0000, 1);

    for (int r = 0; r < 40; r++) begin
      vec_t ra, rb;
      logic [2:0] rs;
      logic [VW-1:0] rm;
      ra = rand_vec(); rb = rand_vec();
      rs = 3'($urandom_range(0, 7));
      rm = (r % 4 == 0) ? {VW{1'b1}} : VW'($urandom);
      model(ra, rb, rs, rm, eo, ef);
      run_op($sformatf("rand%0d op%0d", r, rs), ra, rb, rs, rm, eo, ef, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
